// File: rtl/divisor_bus_master_if.sv
// Request, response and peripheral-bus signals of the divider bus initiator.
// The initiator uses the master view; the requester, consumer and peripheral use slave.
interface divisor_bus_master_if;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_quot;
    logic [1:0]  res_status;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;

    modport master (
        input  op_valid, dividend, divisor, res_ready, bus_rdata,
        output op_ready, res_valid, res_quot, res_status, cs, addr, rd, wr, bus_wdata
    );

    modport slave (
        output op_valid, dividend, divisor, res_ready, bus_rdata,
        input  op_ready, res_valid, res_quot, res_status, cs, addr, rd, wr, bus_wdata
    );
endinterface

// File: rtl/divisor_bus_master.sv
// Sequences one divide on the memory-mapped divider: write operands, pulse START,
// poll DONE, read the result, then return it through a valid/ready response port.
module divisor_bus_master #(
    parameter logic [4:0]  ADDR_DV    = 5'h04,
    parameter logic [4:0]  ADDR_DR    = 5'h08,
    parameter logic [4:0]  ADDR_START = 5'h0C,
    parameter logic [4:0]  ADDR_R     = 5'h10,
    parameter logic [4:0]  ADDR_DONE  = 5'h14,
    parameter int unsigned MAX_POLLS  = 255
) (
    input  logic                  CLK,
    input  logic                  reset,
    divisor_bus_master_if.master  bus
);
    localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);

    typedef enum logic [3:0] {
        IDLE, WR_DV, WR_DR, WR_START1, WR_START0,
        RD_DONE, CHK_DONE, RD_R, CAP_R, RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] dividend_reg, dividend_next;
    logic [15:0] divisor_reg, divisor_next;
    logic [15:0] poll_reg, poll_next;
    logic [15:0] quot_reg, quot_next;
    logic [1:0]  status_reg, status_next;

    logic        cs, rd, wr, op_ready, res_valid;
    logic [4:0]  addr;
    logic [15:0] wdata;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg    <= IDLE;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            poll_reg     <= '0;
            quot_reg     <= '0;
            status_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            poll_reg     <= poll_next;
            quot_reg     <= quot_next;
            status_reg   <= status_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        poll_next     = poll_reg;
        quot_next     = quot_reg;
        status_next   = status_reg;
        cs            = 1'b0;
        rd            = 1'b0;
        wr            = 1'b0;
        addr          = '0;
        wdata         = '0;
        op_ready      = 1'b0;
        res_valid     = 1'b0;

        case (state_reg)
            IDLE: begin
                // Held low during reset so nothing upstream sees a ready it cannot use.
                op_ready = !reset;
                if (bus.op_valid) begin
                    dividend_next = bus.dividend;
                    divisor_next  = bus.divisor;
                    poll_next     = '0;
                    if (bus.divisor == 16'd0) begin
                        quot_next   = 16'hFFFF;
                        status_next = 2'b01;
                        state_next  = RESP;
                    end else begin
                        state_next  = WR_DV;
                    end
                end
            end
            WR_DV: begin
                cs = 1'b1; wr = 1'b1; addr = ADDR_DV; wdata = dividend_reg;
                state_next = WR_DR;
            end
            WR_DR: begin
                cs = 1'b1; wr = 1'b1; addr = ADDR_DR; wdata = divisor_reg;
                state_next = WR_START1;
            end
            WR_START1: begin
                cs = 1'b1; wr = 1'b1; addr = ADDR_START; wdata = 16'h0001;
                state_next = WR_START0;
            end
            WR_START0: begin
                cs = 1'b1; wr = 1'b1; addr = ADDR_START; wdata = 16'h0000;
                state_next = RD_DONE;
            end
            RD_DONE: begin
                cs = 1'b1; rd = 1'b1; addr = ADDR_DONE;
                state_next = CHK_DONE;
            end
            CHK_DONE: begin
                // The peripheral registers read data, so DONE is visible one cycle after its address phase.
                if (bus.bus_rdata[0]) begin
                    state_next = RD_R;
                end else begin
                    poll_next = poll_reg + 16'd1;
                    if (poll_next == POLL_LIMIT) begin
                        quot_next   = 16'h0000;
                        status_next = 2'b10;
                        state_next  = RESP;
                    end else begin
                        state_next  = RD_DONE;
                    end
                end
            end
            RD_R: begin
                cs = 1'b1; rd = 1'b1; addr = ADDR_R;
                state_next = CAP_R;
            end
            CAP_R: begin
                quot_next   = bus.bus_rdata;
                status_next = 2'b00;
                state_next  = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.op_ready   = op_ready;
    assign bus.res_valid  = res_valid;
    assign bus.res_quot   = quot_reg;
    assign bus.res_status = status_reg;
    assign bus.cs         = cs;
    assign bus.rd         = rd;
    assign bus.wr         = wr;
    assign bus.addr       = addr;
    assign bus.bus_wdata  = wdata;
endmodule

// File: tb/tb_divisor_bus_master.sv
// Bench for divisor_bus_master: a registered-read peripheral model plus a
// response scoreboard and an expected-write queue.
module tb_divisor_bus_master;
    localparam int MP = 3;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    divisor_bus_master_if bif();

    divisor_bus_master #(.MAX_POLLS(MP)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        logic [15:0] quot;
        logic [1:0]  status;
        int          lat;
        int          dreads;
        int          rreads;
    } exp_t;

    exp_t        sb[$];
    logic [20:0] wq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          done_after = 0;
    logic [15:0] r_value = '0;
    int          done_reads = 0;
    int          r_reads = 0;
    logic [15:0] pend = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Peripheral: read data appears just after the edge that ends the address phase.
    always @(posedge CLK) begin
        #1;
        bif.bus_rdata = pend;
    end

    always @(negedge CLK) begin
        if (reset) begin
            pend = 16'h0000;
        end else if (bif.cs) begin
            check("rd_wr_excl", 32'(bif.rd & bif.wr), 32'd0);
            if (bif.wr) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", {11'b0, bif.addr, bif.bus_wdata}, 32'hFFFFFFFF);
                end else begin
                    logic [20:0] w;
                    w = wq.pop_front();
                    check("wr_seq", {11'b0, bif.addr, bif.bus_wdata}, {11'b0, w});
                end
            end
            if (bif.rd) begin
                if (bif.addr == 5'h14) begin
                    pend = (done_reads >= done_after) ? 16'h0001 : 16'h0000;
                    done_reads++;
                end else if (bif.addr == 5'h10) begin
                    pend = r_value;
                    r_reads++;
                end else begin
                    check("rd_addr", 32'(bif.addr), 32'h14);
                    pend = 16'hBAD0;
                end
            end else begin
                pend = 16'hBAD0;
            end
        end else begin
            check("bus_quiet", {10'b0, bif.rd, bif.wr, bif.addr, bif.bus_wdata}, 32'd0);
            pend = 16'hBAD0;
        end
    end

    task automatic push_writes(input logic [15:0] dvd, input logic [15:0] dvs);
        wq.push_back({5'h04, dvd});
        wq.push_back({5'h08, dvs});
        wq.push_back({5'h0C, 16'h0001});
        wq.push_back({5'h0C, 16'h0000});
    endtask

    task automatic accept(input logic [15:0] dvd, input logic [15:0] dvs, output int base);
        int n;
        bif.op_valid = 1'b1;
        bif.dividend = dvd;
        bif.divisor  = dvs;
        n = 0;
        while (!bif.op_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("accept_wait", 32'(bif.op_ready), 32'd1);
        base = cyc;
        @(negedge CLK);
        bif.op_valid = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs, input int dafter,
                          input logic [15:0] rval, input int hold,
                          input logic [15:0] eq, input logic [1:0] es, input int elat,
                          input int edr, input int err);
        int base, n, lat, dr0, rr0;
        exp_t e;
        done_after = dafter;
        r_value    = rval;
        dr0 = done_reads;
        rr0 = r_reads;
        sb.push_back('{quot: eq, status: es, lat: elat, dreads: edr, rreads: err});
        if (dvs != 16'd0) push_writes(dvd, dvs);
        accept(dvd, dvs, base);
        n = 0;
        while (!bif.res_valid && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("res_valid_wait", 32'(bif.res_valid), 32'd1);
        lat = cyc - base;
        e = sb.pop_front();
        check("res_quot", 32'(bif.res_quot), 32'(e.quot));
        check("res_status", 32'(bif.res_status), 32'(e.status));
        check("latency", 32'(lat), 32'(e.lat));
        $display("txn %0d/%0d quot=%0d status=%0d lat=%0d", dvd, dvs, bif.res_quot, bif.res_status, lat);
        if (hold > 0) begin
            // A second request waits while the response is stalled.
            bif.op_valid = 1'b1;
            bif.dividend = 16'h1234;
            bif.divisor  = 16'h0002;
            for (int i = 0; i < hold; i++) begin
                @(negedge CLK);
                check("hold_valid", 32'(bif.res_valid), 32'd1);
                check("hold_quot", 32'(bif.res_quot), 32'(e.quot));
                check("hold_status", 32'(bif.res_status), 32'(e.status));
                check("hold_op_ready", 32'(bif.op_ready), 32'd0);
            end
        end
        bif.res_ready = 1'b1;
        @(negedge CLK);
        bif.res_ready = 1'b0;
        bif.op_valid  = 1'b0;
        check("post_res_valid", 32'(bif.res_valid), 32'd0);
        check("post_op_ready", 32'(bif.op_ready), 32'd1);
        check("done_reads", 32'(done_reads - dr0), 32'(e.dreads));
        check("r_reads", 32'(r_reads - rr0), 32'(e.rreads));
        check("wq_drained", 32'(wq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        bif.op_valid  = 1'b0;
        bif.dividend  = '0;
        bif.divisor   = '0;
        bif.res_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_op_ready", 32'(bif.op_ready), 32'd0);
        check("rst_res", {13'b0, bif.res_valid, bif.res_status, bif.res_quot}, 32'd0);
        check("rst_bus", {10'b0, bif.cs, bif.rd, bif.wr, bif.addr, bif.bus_wdata}, 32'd0);
        reset = 1'b0;
        @(negedge CLK);
        check("rel_op_ready", 32'(bif.op_ready), 32'd1);
        check("rel_res_valid", 32'(bif.res_valid), 32'd0);

        // Fields: dividend, divisor, DONE=0 count, R, hold, quot, status, latency, DONE reads, R reads.
        run_op(16'd100, 16'd7, 2, 16'd14, 0, 16'd14, 2'b00, 13, 3, 1);
        run_op(16'd55, 16'd0, 0, 16'd0, 0, 16'hFFFF, 2'b01, 1, 0, 0);
        run_op(16'd9, 16'd3, 1000, 16'd77, 0, 16'd0, 2'b10, 2 * MP + 5, MP, 0);
        run_op(16'd1000, 16'd10, 0, 16'd100, 10, 16'd100, 2'b00, 9, 1, 1);

        // Abort an operation while it is checking DONE.
        done_after = 1000;
        push_writes(16'd50, 16'd5);
        accept(16'd50, 16'd5, base);
        n = 0;
        while ((cyc - base) < 6 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("abort_chk_cs", 32'(bif.cs), 32'd0);
        reset = 1'b1;
        @(negedge CLK);
        check("abort_bus", {10'b0, bif.cs, bif.rd, bif.wr, bif.addr, bif.bus_wdata}, 32'd0);
        check("abort_op_ready", 32'(bif.op_ready), 32'd0);
        check("abort_res_valid", 32'(bif.res_valid), 32'd0);
        check("abort_wq", 32'(wq.size()), 32'd0);
        reset = 1'b0;
        @(negedge CLK);
        check("abort_rel_ready", 32'(bif.op_ready), 32'd1);
        run_op(16'd65535, 16'd1, 0, 16'd65535, 0, 16'd65535, 2'b00, 9, 1, 1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/divisor_bus_master.md
# divisor_bus_master

Bus initiator that drives the memory-mapped divider peripheral on its 16-bit peripheral bus. It accepts one dividend/divisor pair through a valid/ready request port and performs the full bus transaction sequence:

- write DV and DR
- pulse START
- poll DONE
- read R

It then returns the result and a status code through a valid/ready response port. It sits between the calculator control logic and the peripheral bus, so the control logic does not sequence bus cycles.

## Interface
Parameters:
- ADDR_DV, 5'h04, dividend register address
- ADDR_DR, 5'h08, divisor register address
- ADDR_START, 5'h0C, start register address
- ADDR_R, 5'h10, result register address
- ADDR_DONE, 5'h14, done flag address
- MAX_POLLS, 255, number of DONE reads returning 0 before timeout (1..65535)

Ports:
- Clock and reset. One clock; reset is synchronous and active-high.
  - CLK  in  1  clock
  - reset  in  1  synchronous active-high reset
- Request port:
  - op_valid  in  1  request valid
  - op_ready  out  1  high only in IDLE
  - dividend  in  16  operand, sampled on accept
  - divisor  in  16  operand, sampled on accept
- Response port:
  - res_valid  out  1  response valid
  - res_ready  in  1  consumer accepts response
  - res_quot  out  16  result value
  - res_status  out  2  00 ok, 01 divide-by-zero, 10 timeout
- Peripheral bus:
  - cs  out  1  chip select
  - addr  out  5  register address
  - rd  out  1  read strobe
  - wr  out  1  write strobe
  - bus_wdata  out  16  write data to peripheral
  - bus_rdata  in  16  registered read data from peripheral

## Operation
- FSM states: IDLE, WR_DV, WR_DR, WR_START1, WR_START0, RD_DONE, CHK_DONE, RD_R, CAP_R, RESP.
- Accept occurs when op_valid && op_ready. On accept, dividend and divisor are latched and the poll counter is cleared.
  - If divisor == 0: go to RESP with res_quot = 16'hFFFF and res_status = 01. No bus cycles are issued.
  - Otherwise: go to WR_DV.
- Write states last one cycle each, with cs=1, wr=1, rd=0:
  - WR_DV: addr=ADDR_DV, data=dividend
  - WR_DR: addr=ADDR_DR, data=divisor
  - WR_START1: addr=ADDR_START, data=16'h0001
  - WR_START0: addr=ADDR_START, data=16'h0000
- RD_DONE drives cs=1, rd=1, addr=ADDR_DONE. CHK_DONE drives cs=0 and samples bus_rdata[0].
  - If bit 0 = 1: go to RD_R.
  - If bit 0 = 0: increment the poll counter. If the counter equals MAX_POLLS, go to RESP with res_quot=0 and status 10; otherwise return to RD_DONE.
- RD_R drives cs=1, rd=1, addr=ADDR_R. CAP_R latches bus_rdata into res_quot with status 00, then goes to RESP.
- In RESP, res_valid=1 and res_quot/res_status are held stable. On res_ready, go to IDLE.
- In every state other than the write and read states, cs, rd, wr, addr and bus_wdata are 0. rd and wr are never high together.

## Timing
- Reset values:
  - op_ready=0 while reset is asserted, 1 in the first cycle after reset is released.
  - res_valid=0, res_quot=0, res_status=0.
  - cs=rd=wr=0, addr=0, bus_wdata=0.
- Reset asserted mid-operation returns the FSM to IDLE on the next edge and drops all bus strobes. The peripheral is reset by the same signal.
- Read protocol: the address phase is cycle N; bus_rdata is valid and sampled in cycle N+1 (the peripheral registers its read data).
- Latency is counted from the accept edge:
  - The bus sequence occupies cycles 1–4.
  - The first DONE address phase is in cycle 5.
  - With DONE=1 on the first poll, res_valid rises in cycle 9.
  - Each additional poll adds 2 cycles.
- Divide-by-zero: res_valid rises in cycle 1 after accept.
- Timeout: res_valid rises 2·MAX_POLLS+5 cycles after accept.
- op_ready is low from accept until the cycle after the response handshake. A new request is therefore never accepted in the same cycle as res_ready.
- res_ready while res_valid=0 is ignored. op_valid outside IDLE is ignored; the requester must hold it.

## Test plan
- Reset release: all outputs are at their reset values, and op_ready=1 one cycle later.
- 100/7 with a bus model that returns DONE=0 twice, then 1, and R=14:
  - exact write sequence is 04←100, 08←7, 0C←1, 0C←0
  - three DONE reads are issued
  - one R read is issued
  - res_quot=14, res_status=00, res_valid in cycle 13
- Divisor 0: no cs activity; res_quot=16'hFFFF and res_status=01 in cycle 1.
- MAX_POLLS=3 with DONE stuck at 0: exactly 3 DONE reads, then res_status=10 and res_quot=0.
- res_ready held low for 10 cycles: the response stays stable, op_ready stays 0, and a second op_valid is not accepted until after the handshake.
- Reset pulsed during CHK_DONE: FSM returns to IDLE, strobes go to 0, and a following 65535/1 operation returns 65535.
